gray_counter: RTL and testbench

Parametrised, registered Gray-code counter, the sequential successor to the combinational 4-bit binary-to-Gray converter. It holds a WIDTH-bit binary count and its Gray equivalent in registers, updated on the same edge. It supports up/down counting, enable, parallel load and selectable wrap/saturate behaviour, and flags terminal-count events. It is intended as the pointer and position source for blocks that need single-bit-change encodings, such as async FIFO pointers and encoder position tracking.

---
 rtl/gray_counter.sv | 31 +++
 tb/tb_gray_counter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// gray_counter: registered up/down Gray counter with load, wrap/saturate and terminal-count flag
module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] G,
  output logic             tc
);
  localparam logic [WIDTH-1:0] one = WIDTH'(1);
  logic [WIDTH-1:0] b_nxt, step;
  logic at_end, tc_nxt;
  always_comb begin
    at_end = up ? &B : ~|B;
    step   = up ? B + one : B - one;
    b_nxt  = rst ? '0 : load ? D : !en ? B : (at_end && !WRAP) ? B : step;
    tc_nxt = !rst && !load && en && at_end;
  end
  // G is encoded from next-state B so both outputs move on the same edge
  always_ff @(posedge clk) begin
    B  <= b_nxt;
    G  <= b_nxt ^ (b_nxt >> 1);
    tc <= tc_nxt;
  end
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed + random scoreboard bench for wrap, saturate and 9-bit counters
module tb_gray_counter;
  logic clk = 1'b0;
  logic rst = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
  logic [3:0] d4 = '0;
  logic [8:0] d9 = '0;
  logic [3:0] bw, gw, bs, gs;
  logic [8:0] bn, gn;
  logic tw, ts, tn;
  int checks = 0, failures = 0;
  int mw = 0, ms = 0, mn = 0;

  typedef struct {
    int wb; int wg; bit wt;
    int sb; bit st;
    int nb; bit nt;
    bit plain; bit en;
  } sb_t;
  sb_t q[$];

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .WRAP(1'b1)) dut_w (.clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d4), .B(bw), .G(gw), .tc(tw));
  gray_counter #(.WIDTH(4), .WRAP(1'b0)) dut_s (.clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d4), .B(bs), .G(gs), .tc(ts));
  gray_counter #(.WIDTH(9), .WRAP(1'b1)) dut_n (.clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d9), .B(bn), .G(gn), .tc(tn));

  task automatic chk(input string n, input int a, input int x);
    checks++;
    if (a != x) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, x);
    end
  endtask

  function automatic void mdl(input int b, input int mx, input bit wrap, input bit r, input bit l,
                              input bit e, input bit u, input int d, output int nb, output bit nt);
    nt = 1'b0;
    nb = b;
    if (r) nb = 0;
    else if (l) nb = d;
    else if (e && u) begin
      if (b == mx) begin nt = 1'b1; nb = wrap ? 0 : b; end
      else nb = b + 1;
    end else if (e) begin
      if (b == 0) begin nt = 1'b1; nb = wrap ? mx : 0; end
      else nb = b - 1;
    end
  endfunction

  task automatic apply(input bit r, input bit l, input bit e, input bit u, input int d,
                       input int wb, input int wg, input bit wt, input int sb, input bit st);
    sb_t x;
    int nb;
    bit nt;
    @(negedge clk);
    rst = r; load = l; en = e; up = u;
    d4 = d[3:0];
    d9 = d[8:0];
    mdl(mn, 511, 1'b1, r, l, e, u, d & 511, nb, nt);
    mn = nb;
    mw = wb;
    ms = sb;
    x.wb = wb; x.wg = wg; x.wt = wt;
    x.sb = sb; x.st = st;
    x.nb = nb; x.nt = nt;
    x.plain = !r && !l;
    x.en = e;
    q.push_back(x);
  endtask

  initial begin : monitor
    sb_t e;
    int pgw = 0, pgn = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wrap_B", int'(bw), e.wb);
        chk("wrap_G", int'(gw), e.wg);
        chk("wrap_tc", int'(tw), int'(e.wt));
        chk("sat_B", int'(bs), e.sb);
        chk("sat_G", int'(gs), e.sb ^ (e.sb >> 1));
        chk("sat_tc", int'(ts), int'(e.st));
        chk("w9_B", int'(bn), e.nb);
        chk("w9_G", int'(gn), e.nb ^ (e.nb >> 1));
        chk("w9_tc", int'(tn), int'(e.nt));
        if (e.plain) begin
          chk("wrap_gray_bits", $countones(gw ^ pgw[3:0]), e.en ? 1 : 0);
          chk("w9_gray_bits", $countones(gn ^ pgn[8:0]), e.en ? 1 : 0);
        end
        pgw = int'(gw);
        pgn = int'(gn);
      end
    end
  end

  initial begin : stim
    int gup [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                     4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    apply(1, 0, 0, 0, 0,       0, 4'b0000, 0,  0, 0);
    for (int i = 0; i < 16; i++)
      apply(0, 0, 1, 1, 0, (i + 1) % 16, gup[i], i == 15, (i < 15) ? i + 1 : 15, i == 15);
    apply(0, 0, 1, 0, 0,      15, 4'b1000, 1, 14, 0);
    apply(0, 0, 1, 0, 0,      14, 4'b1001, 0, 13, 0);
    apply(0, 1, 1, 1, 4'b1010, 10, 4'b1111, 0, 10, 0);
    apply(0, 0, 1, 1, 0,      11, 4'b1110, 0, 11, 0);
    apply(0, 0, 0, 1, 0,      11, 4'b1110, 0, 11, 0);
    apply(0, 1, 0, 0, 4'b1111, 15, 4'b1000, 0, 15, 0);
    apply(0, 0, 1, 1, 0,       0, 4'b0000, 1, 15, 1);
    apply(0, 0, 1, 1, 0,       1, 4'b0001, 0, 15, 1);
    apply(0, 0, 1, 1, 0,       2, 4'b0011, 0, 15, 1);
    apply(0, 0, 1, 0, 0,       1, 4'b0001, 0, 14, 0);
    apply(0, 1, 0, 1, 4'b0110,  6, 4'b0101, 0,  6, 0);
    apply(1, 1, 1, 1, 4'b0101,  0, 4'b0000, 0,  0, 0);
    apply(0, 0, 1, 1, 0,       1, 4'b0001, 0,  1, 0);
    apply(0, 0, 1, 0, 0,       0, 4'b0000, 0,  0, 0);
    apply(0, 0, 1, 0, 0,      15, 4'b1000, 1,  0, 1);
    apply(0, 0, 1, 0, 0,      14, 4'b1001, 0,  0, 1);
    apply(0, 0, 1, 1, 0,      15, 4'b1000, 0,  1, 0);
    apply(0, 0, 0, 1, 0,      15, 4'b1000, 0,  1, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, l, e, u;
      int d, wb, sb;
      bit wt, st;
      r = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = $urandom_range(0, 3) != 0;
      u = $urandom_range(0, 1) == 1;
      d = $urandom_range(0, 511);
      mdl(mw, 15, 1'b1, r, l, e, u, d & 15, wb, wt);
      mdl(ms, 15, 1'b0, r, l, e, u, d & 15, sb, st);
      apply(r, l, e, u, d, wb, wb ^ (wb >> 1), wt, sb, st);
    end
    @(negedge clk);
    en = 1'b0; load = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
